// File: rtl/arch_defs_pkg.sv
// Shared architectural constants and types for the memory-bus arbiter and its neighbours.
package arch_defs_pkg;

    localparam int          DATA_WIDTH_DEF = 8;
    localparam int          ADDR_WIDTH_DEF = 16;
    localparam logic [15:0] RESET_VECTOR   = 16'hF000;

    typedef enum logic [1:0] {
        S_ARB_CPU_PRI   = 2'd0,
        S_ARB_DBG_FORCE = 2'd1,
        S_ARB_DBG_LOCK  = 2'd2
    } arb_state_t;

    // Width of a counter that must be able to hold the value max_wait.
    function automatic int wait_cnt_width(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Single-port RAM arbiter: CPU priority, debug starvation guard and debug bus lock.
// Optional CPU write protection of ROM space is built when WRITE_PROTECT_EN is defined.
//
// Handshake: a requester raises *_req with we/addr/wdata stable and holds it until it
// sees *_gnt in the same cycle; every gnt cycle is exactly one access. Writes complete in
// the gnt cycle; read data is presented on rdata with *_rvalid one cycle after the gnt.
module mem_bus_arbiter
    import arch_defs_pkg::*;
#(
    parameter int                     DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int                     ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int                     MAX_WAIT   = 15,
    parameter logic [ADDR_WIDTH-1:0]  ROM_BASE   = ADDR_WIDTH'(RESET_VECTOR),
    localparam int                    CNT_W      = wait_cnt_width(MAX_WAIT)
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic                  cpu_wr_fault,

    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    input  logic                  dbg_lock,

    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,

    output arb_state_t            state_o,
    output logic [CNT_W-1:0]      wait_cnt_o
);

    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             rd_cpu_q, rd_cpu_d;
    logic             rd_dbg_q, rd_dbg_d;
    logic             cpu_gnt_w, dbg_gnt_w;
    logic             cpu_wr_blocked;

    // Grant decode; reset is an asynchronous level, so grants are suppressed directly by it.
    always_comb begin
        cpu_gnt_w = 1'b0;
        dbg_gnt_w = 1'b0;
        case (state_q)
            S_ARB_CPU_PRI: begin
                cpu_gnt_w = cpu_req;
                dbg_gnt_w = dbg_req & ~cpu_req;
            end
            S_ARB_DBG_FORCE: begin
                dbg_gnt_w = dbg_req;
                cpu_gnt_w = cpu_req & ~dbg_req;
            end
            S_ARB_DBG_LOCK: begin
                dbg_gnt_w = dbg_req;
            end
            default: ;
        endcase
        if (reset) begin
            cpu_gnt_w = 1'b0;
            dbg_gnt_w = 1'b0;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!dbg_req || dbg_gnt_w) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // The force is keyed on the counter's next value so it takes effect in the very
    // cycle after the counter reaches MAX_WAIT.
    always_comb begin
        state_d = state_q;
        if (dbg_gnt_w && dbg_lock) begin
            state_d = S_ARB_DBG_LOCK;
        end else begin
            case (state_q)
                S_ARB_CPU_PRI:   if (wait_cnt_d == WAIT_MAX) state_d = S_ARB_DBG_FORCE;
                S_ARB_DBG_FORCE: state_d = S_ARB_CPU_PRI;
                S_ARB_DBG_LOCK:  if (!dbg_lock) state_d = S_ARB_CPU_PRI;
                default:         state_d = S_ARB_CPU_PRI;
            endcase
        end
    end

`ifdef WRITE_PROTECT_EN
    logic wr_fault_q, wr_fault_d;

    assign cpu_wr_blocked = cpu_gnt_w & cpu_we & (cpu_addr >= ROM_BASE);
    assign wr_fault_d     = cpu_wr_blocked;
    assign cpu_wr_fault   = wr_fault_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wr_fault_q <= 1'b0;
        else       wr_fault_q <= wr_fault_d;
    end
`else
    assign cpu_wr_blocked = 1'b0;
    assign cpu_wr_fault   = 1'b0;
`endif

    // Idle bus still drives CPU address/data so the mux output is always defined.
    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = 1'b0;
        if (dbg_gnt_w) begin
            ram_addr  = dbg_addr;
            ram_wdata = dbg_wdata;
            ram_we    = dbg_we;
        end else if (cpu_gnt_w) begin
            ram_we    = cpu_we & ~cpu_wr_blocked;
        end
    end

    assign rd_cpu_d = cpu_gnt_w & ~cpu_we;
    assign rd_dbg_d = dbg_gnt_w & ~dbg_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_ARB_CPU_PRI;
            wait_cnt_q <= '0;
            rd_cpu_q   <= 1'b0;
            rd_dbg_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rd_cpu_q   <= rd_cpu_d;
            rd_dbg_q   <= rd_dbg_d;
        end
    end

    assign cpu_gnt    = cpu_gnt_w;
    assign dbg_gnt    = dbg_gnt_w;
    assign cpu_rvalid = rd_cpu_q;
    assign dbg_rvalid = rd_dbg_q;
    assign rdata      = ram_rdata;
    assign state_o    = state_q;
    assign wait_cnt_o = wait_cnt_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboarded bench for mem_bus_arbiter: directed vectors, read responses checked by a monitor.
module tb_mem_bus_arbiter;
    import arch_defs_pkg::*;

`ifdef WRITE_PROTECT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_gnt, cpu_rvalid, cpu_wr_fault;
    logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
    logic [15:0] dbg_addr = '0;
    logic [7:0]  dbg_wdata = '0;
    logic        dbg_gnt, dbg_rvalid;
    logic [7:0]  ram_rdata = '0;
    logic [7:0]  rdata;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    arb_state_t  state_o;
    logic [3:0]  wait_cnt_o;

    int tests_run = 0;
    int fail_cnt  = 0;
    logic [7:0] exp_cpu_q[$];
    logic [7:0] exp_dbg_q[$];
    logic [7:0] mem [0:65535];

    mem_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_wr_fault(cpu_wr_fault),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_lock(dbg_lock),
        .ram_rdata(ram_rdata), .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .state_o(state_o), .wait_cnt_o(wait_cnt_o)
    );

    // Clock and synchronous read-first RAM model
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; checks follow 1 time unit later.
    task automatic drive(input logic c_req, input logic c_we, input logic [15:0] c_addr,
                         input logic [7:0] c_wd, input logic d_req, input logic d_we,
                         input logic [15:0] d_addr, input logic [7:0] d_wd, input logic d_lock);
        @(negedge clk);
        cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
        dbg_req = d_req; dbg_we = d_we; dbg_addr = d_addr; dbg_wdata = d_wd;
        dbg_lock = d_lock;
        #1;
        check("gnt_exclusive", 32'(cpu_gnt & dbg_gnt), 32'd0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    endtask

    // 15 cycles of contention: CPU wins each one while the debug counter climbs.
    task automatic contend15(input logic d_we, input logic [15:0] d_addr,
                             input logic [7:0] d_wd, input logic d_lock);
        for (int c = 1; c <= 15; c++) begin
            drive(1'b1, 1'b0, 16'h0200, 8'h00, 1'b1, d_we, d_addr, d_wd, d_lock);
            check("contend_cpu_gnt", 32'(cpu_gnt), 32'd1);
            check("contend_dbg_gnt", 32'(dbg_gnt), 32'd0);
            check("contend_wait_cnt", 32'(wait_cnt_o), 32'(c - 1));
            check("contend_state", 32'(state_o), 32'(S_ARB_CPU_PRI));
            exp_cpu_q.push_back(8'h5A);
        end
    endtask

    // Monitor: every rvalid must match the oldest outstanding expected read.
    always @(negedge clk) begin
        logic [7:0] exp;
        if (cpu_rvalid) begin
            tests_run++;
            if (exp_cpu_q.size() == 0) begin
                fail_cnt++;
                $display("FAIL cpu_rvalid_unexpected: rdata %0h, expected no response", rdata);
            end else begin
                exp = exp_cpu_q.pop_front();
                if (rdata !== exp) begin
                    fail_cnt++;
                    $display("FAIL cpu_rdata: got %0h, expected %0h", rdata, exp);
                end
            end
        end
        if (dbg_rvalid) begin
            tests_run++;
            if (exp_dbg_q.size() == 0) begin
                fail_cnt++;
                $display("FAIL dbg_rvalid_unexpected: rdata %0h, expected no response", rdata);
            end else begin
                exp = exp_dbg_q.pop_front();
                if (rdata !== exp) begin
                    fail_cnt++;
                    $display("FAIL dbg_rdata: got %0h, expected %0h", rdata, exp);
                end
            end
        end
    end

    initial begin
        #200000;
        fail_cnt++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

    initial begin
        logic d_req_v;
        mem[16'h0200] = 8'h5A;
        mem[16'h0300] = 8'hC3;

        // Reset: requests high but no grants may appear
        drive(1'b1, 1'b1, 16'h0200, 8'h11, 1'b1, 1'b1, 16'h0300, 8'h22, 1'b0);
        check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        check("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        check("rst_wr_fault", 32'(cpu_wr_fault), 32'd0);
        check("rst_state", 32'(state_o), 32'(S_ARB_CPU_PRI));
        check("rst_wait_cnt", 32'(wait_cnt_o), 32'd0);
        idle();
        reset = 1'b0;
        idle();

        // Uncontended CPU read at 0x0200
        drive(1'b1, 1'b0, 16'h0200, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        check("cpu_rd_gnt", 32'(cpu_gnt), 32'd1);
        check("cpu_rd_ram_addr", 32'(ram_addr), 32'h0200);
        check("cpu_rd_ram_we", 32'(ram_we), 32'd0);
        exp_cpu_q.push_back(8'h5A);
        idle();
        check("cpu_rd_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        check("cpu_rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);

        // Continuous contention: force on cycle 16, CPU back on 17
        contend15(1'b0, 16'h0300, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 16'h0200, 8'h00, 1'b1, 1'b0, 16'h0300, 8'h00, 1'b0);
        check("force_state", 32'(state_o), 32'(S_ARB_DBG_FORCE));
        check("force_wait_cnt", 32'(wait_cnt_o), 32'd15);
        check("force_dbg_gnt", 32'(dbg_gnt), 32'd1);
        check("force_cpu_gnt", 32'(cpu_gnt), 32'd0);
        check("force_ram_addr", 32'(ram_addr), 32'h0300);
        exp_dbg_q.push_back(8'hC3);
        drive(1'b1, 1'b0, 16'h0200, 8'h00, 1'b1, 1'b0, 16'h0300, 8'h00, 1'b0);
        check("resume_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check("resume_dbg_gnt", 32'(dbg_gnt), 32'd0);
        check("resume_state", 32'(state_o), 32'(S_ARB_CPU_PRI));
        check("resume_wait_cnt", 32'(wait_cnt_o), 32'd0);
        exp_cpu_q.push_back(8'h5A);
        idle();

        // Debug drops its request in the forced cycle: CPU takes it
        contend15(1'b0, 16'h0300, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 16'h0200, 8'h00, 1'b0, 1'b0, 16'h0300, 8'h00, 1'b0);
        check("fdrop_state", 32'(state_o), 32'(S_ARB_DBG_FORCE));
        check("fdrop_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check("fdrop_dbg_gnt", 32'(dbg_gnt), 32'd0);
        exp_cpu_q.push_back(8'h5A);
        idle();
        check("fdrop_back_state", 32'(state_o), 32'(S_ARB_CPU_PRI));

        // Lock: held from the start but only takes effect at the first debug grant
        contend15(1'b1, 16'hF000, 8'h10, 1'b1);
        drive(1'b1, 1'b0, 16'h0200, 8'h00, 1'b1, 1'b1, 16'hF000, 8'h10, 1'b1);
        check("lock_first_dbg_gnt", 32'(dbg_gnt), 32'd1);
        check("lock_first_ram_we", 32'(ram_we), 32'd1);
        check("lock_first_ram_addr", 32'(ram_addr), 32'hF000);
        for (int i = 0; i < 5; i++) begin
            d_req_v = (i != 1) && (i != 4);
            drive(1'b1, 1'b0, 16'h0200, 8'h00, d_req_v, 1'b1, 16'hF000 + 16'(i), 8'h10 + 8'(i), (i != 4));
            check("lock_state", 32'(state_o), 32'(S_ARB_DBG_LOCK));
            check("lock_cpu_gnt", 32'(cpu_gnt), 32'd0);
            check("lock_dbg_gnt", 32'(dbg_gnt), 32'(d_req_v));
        end
        drive(1'b1, 1'b0, 16'h0200, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        check("unlock_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check("unlock_state", 32'(state_o), 32'(S_ARB_CPU_PRI));
        exp_cpu_q.push_back(8'h5A);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'hF002, 8'h00, 1'b0);
        check("lock_rb_gnt", 32'(dbg_gnt), 32'd1);
        exp_dbg_q.push_back(8'h12);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'hF003, 8'h00, 1'b0);
        exp_dbg_q.push_back(8'h13);
        idle();

        // CPU write into ROM space, then debug programs it and reads back
        drive(1'b1, 1'b1, 16'hF010, 8'h77, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        check("wp_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check("wp_ram_we", 32'(ram_we), 32'(!WP));
        idle();
        check("wp_fault", 32'(cpu_wr_fault), 32'(WP));
        idle();
        check("wp_fault_pulse", 32'(cpu_wr_fault), 32'd0);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 16'hF010, 8'h77, 1'b0);
        check("wp_dbg_ram_we", 32'(ram_we), 32'd1);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'hF010, 8'h00, 1'b0);
        exp_dbg_q.push_back(8'h77);
        idle();
        check("wp_dbg_fault", 32'(cpu_wr_fault), 32'd0);

        // Debug-only toggling: immediate grant, counter stays at zero
        for (int i = 0; i < 6; i++) begin
            d_req_v = (i % 2 == 0);
            drive(1'b0, 1'b0, 16'h0000, 8'h00, d_req_v, 1'b0, 16'h0300, 8'h00, 1'b0);
            check("tog_dbg_gnt", 32'(dbg_gnt), 32'(d_req_v));
            check("tog_cpu_gnt", 32'(cpu_gnt), 32'd0);
            check("tog_wait_cnt", 32'(wait_cnt_o), 32'd0);
            if (d_req_v) exp_dbg_q.push_back(8'hC3);
        end
        idle();

        // Reset right after a granted CPU read: the response is discarded
        drive(1'b1, 1'b0, 16'h0200, 8'h00, 1'b1, 1'b0, 16'h0300, 8'h00, 1'b0);
        check("mrst_cpu_gnt", 32'(cpu_gnt), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        #1;
        check("mrst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check("mrst_cpu_gnt_low", 32'(cpu_gnt), 32'd0);
        check("mrst_dbg_gnt_low", 32'(dbg_gnt), 32'd0);
        check("mrst_ram_we", 32'(ram_we), 32'd0);
        check("mrst_state", 32'(state_o), 32'(S_ARB_CPU_PRI));
        idle();
        reset = 1'b0;
        idle();
        idle();

        check("cpu_queue_empty", 32'(exp_cpu_q.size()), 32'd0);
        check("dbg_queue_empty", 32'(exp_dbg_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single synchronous RAM port between the CPU datapath (fetch, operand, stack accesses) and the UART loader/debug monitor. It grants at most one requester per cycle. Under contention the CPU wins by default. The debug side has a starvation guard and a bus-lock mode for program loading. It sits between the control/MAR logic, the UART command block and the RAM.

## Interface
Parameters:
- DATA_WIDTH, 8, data bus width
- ADDR_WIDTH, 16, address width
- MAX_WAIT, 15, consecutive cycles debug may be denied before a forced grant (1..255)
- ROM_BASE, 16'hF000, lowest write-protected address (equals reset vector)

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request; addr/we/wdata stable while high
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  CPU address
- cpu_wdata  in  DATA_WIDTH  CPU write data
- cpu_gnt  out  1  access issued this cycle (combinational)
- cpu_rvalid  out  1  read data valid for CPU
- cpu_wr_fault  out  1  one-cycle pulse: CPU write to protected region dropped
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid: same meaning as the cpu_* ports, for the debug/loader requester
- dbg_lock  in  1  debug requests exclusive ownership while high
- rdata  out  DATA_WIDTH  ram_rdata passed through; qualified by *_rvalid
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH  RAM address, muxed from granted requester
- ram_wdata  out  DATA_WIDTH  RAM write data

## Operation
State machine arb_state_t has three states:
- S_ARB_CPU_PRI: cpu_gnt = cpu_req; dbg_gnt = dbg_req & ~cpu_req.
- S_ARB_DBG_FORCE: dbg_gnt = dbg_req; cpu_gnt = cpu_req & ~dbg_req.
- S_ARB_DBG_LOCK: dbg_gnt = dbg_req; cpu_gnt = 0 unconditionally, even if dbg_req = 0.

Transitions:
- CPU_PRI → DBG_FORCE when wait_cnt == MAX_WAIT.
- Any state → DBG_LOCK when dbg_gnt & dbg_lock.
- DBG_LOCK → CPU_PRI when dbg_lock = 0.
- DBG_FORCE → CPU_PRI after one cycle, unless it enters DBG_LOCK.

Starvation counter wait_cnt (width $clog2(MAX_WAIT+1)):
- Increments when dbg_req & ~dbg_gnt.
- Clears when dbg_gnt or ~dbg_req.
- Saturates at MAX_WAIT.

RAM drive:
- With no grant: ram_we = 0 and ram_addr/ram_wdata = CPU values, so the mux is don't-care-free.
- Otherwise ram_we = granted_we (subject to write protection).

Read return:
- Registered flags rd_cpu_q and rd_dbg_q record a granted read.
- *_rvalid equal those flags; rdata = ram_rdata.

Grants are never both high.

## Timing
Reset values: state = S_ARB_CPU_PRI, wait_cnt = 0, cpu_rvalid = dbg_rvalid = 0, cpu_wr_fault = 0. All *_gnt and ram_we are forced 0 while reset is high.

Latency and handshake:
- Grant is in the same cycle as the request (zero latency when uncontended).
- Read data is valid exactly one cycle after the grant cycle.
- Writes complete in the grant cycle.
- A requester keeps req high until it sees gnt. Each gnt cycle is exactly one access. Back-to-back grants to the same requester are allowed every cycle.

Boundary conditions:
- Both requesters at MAX_WAIT boundary: the force applies on the cycle after wait_cnt reaches MAX_WAIT.
- dbg_req drops during DBG_FORCE: the CPU is granted that cycle and the state returns to CPU_PRI.
- dbg_lock rising while debug is not granted has no effect until a dbg grant occurs.
- Reset mid-read: pending rvalid is cleared and no response is delivered.

## Configuration
Macro WRITE_PROTECT_EN:
- Defined: a granted CPU write with cpu_addr >= ROM_BASE forces ram_we = 0, still consumes the grant, and pulses cpu_wr_fault high one cycle later. Debug writes are never protected, so the loader can program ROM space.
- Undefined: all writes pass through and cpu_wr_fault is tied to 0.

## Structure
- arb_state_t enum (S_ARB_CPU_PRI, S_ARB_DBG_FORCE, S_ARB_DBG_LOCK) goes in arch_defs_pkg.
- The ROM_BASE default comes from RESET_VECTOR in arch_defs_pkg. DATA_WIDTH and ADDR_WIDTH defaults come from the package.
- No sub-module: the counter, FSM and mux stay in one module.

## Test plan
- CPU read at 0x0200 alone, RAM holds 0x5A → cpu_gnt in the same cycle; cpu_rvalid = 1 with rdata = 0x5A next cycle; dbg_rvalid = 0.
- Both req held continuously, MAX_WAIT = 15 → CPU granted 15 cycles, dbg granted on cycle 16, CPU resumes on cycle 17; wait_cnt back to 0.
- dbg_lock = 1 with a dbg write burst 0xF000..0xF003, CPU req high throughout → cpu_gnt = 0 for the whole lock including idle gaps; the CPU is granted in the cycle after dbg_lock falls.
- WRITE_PROTECT_EN defined, CPU writes 0x77 to 0xF010 → ram_we = 0 and cpu_wr_fault pulses next cycle. A dbg write to the same address succeeds and a readback returns 0x77.
- Reset asserted in the cycle after a granted CPU read → cpu_rvalid = 0, state = CPU_PRI, and no grants while reset is high.
- Alternating dbg_req toggles with CPU idle → dbg granted immediately each time; wait_cnt never exceeds 0.
